// File: rtl/umem_pkg.sv
// Shared definitions for the unified-memory responder: line geometry, state encoding
// and the word-address to line-index helper.
package umem_pkg;

    localparam int UMEM_ADDR_W    = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = 16 * WORDS_PER_LINE;
    localparam int UMEM_LATENCY   = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        RESP = ST_RESP
    } state_e;

    function automatic logic [31:0] line_index(input logic [31:0] addr);
        return addr >> $clog2(WORDS_PER_LINE);
    endfunction

endpackage

// File: rtl/umem_array.sv
// Line-organised backing store: single write/read port with a registered read, plus a
// load port that lets a system initialise contents without going through the handshake.
module umem_array
    import umem_pkg::*;
#(
    parameter int IDX_W = 14,
    parameter int DEPTH = 2 ** IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              ld_we_i,
    input  logic [IDX_W-1:0]  ld_idx_i,
    input  logic [LINE_W-1:0] ld_data_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [LINE_W-1:0] wr_data;

    // The load port has priority; it is only used outside normal traffic.
    assign wr_en   = we_i | ld_we_i;
    assign wr_idx  = ld_we_i ? ld_idx_i  : idx_i;
    assign wr_data = ld_we_i ? ld_data_i : wdata_i;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/unified_mem_resp.sv
// Unified-memory responder: serves whole-line reads/writes with a fixed latency and a
// one-cycle ready pulse. Define UMEM_PROTO_CHK_EN to build the sticky protocol checker.
module unified_mem_resp
    import umem_pkg::*;
#(
    parameter int ADDR_W  = UMEM_ADDR_W,
    parameter int LATENCY = UMEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_re,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [LINE_W-1:0] u_wdata,
    output logic [LINE_W-1:0] u_rdata,
    output logic              u_rdy,
    output logic              u_busy,
    output logic              u_err
);

    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_we_q, op_we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  req_idx;
    logic              mem_we, mem_re;

    assign req_idx = IDX_W'(line_index(32'(u_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_we_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (u_re | u_we) begin
                    // A write wins over a simultaneous read; the read is simply dropped.
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    op_we_d = u_we;
                    idx_d   = req_idx;
                    wdata_d = u_wdata;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    mem_we  = op_we_q;
                    mem_re  = ~op_we_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    umem_array #(
        .IDX_W (IDX_W),
        .DEPTH (2 ** IDX_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (mem_we),
        .re_i      (mem_re),
        .idx_i     (idx_q),
        .wdata_i   (wdata_q),
        .ld_we_i   (1'b0),
        .ld_idx_i  ('0),
        .ld_data_i ('0),
        .rdata_o   (u_rdata)
    );

    assign u_rdy  = (state_q == RESP);
    assign u_busy = (state_q != IDLE);

`ifdef UMEM_PROTO_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && u_re && u_we) begin
            err_d = 1'b1;
        end
        if (state_q == BUSY && (req_idx != idx_q || !(u_re | u_we))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign u_err = err_q;
`else
    assign u_err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_resp.sv
// Directed bench for unified_mem_resp: a timestamp-based reference model checked every
// cycle, plus literal expectations on latency and returned data.
module tb_unified_mem_resp;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        u_re = 1'b0;
    logic        u_we = 1'b0;
    logic [15:0] u_addr = '0;
    logic [63:0] u_wdata = '0;
    logic [63:0] u_rdata;
    logic        u_rdy;
    logic        u_busy;
    logic        u_err;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    unified_mem_resp #(.ADDR_W(16), .LATENCY(LAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .u_re    (u_re),
        .u_we    (u_we),
        .u_addr  (u_addr),
        .u_wdata (u_wdata),
        .u_rdata (u_rdata),
        .u_rdy   (u_rdy),
        .u_busy  (u_busy),
        .u_err   (u_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: a request accepted at edge A completes (memory op, ready) at edge
    // A+LAT and the responder is free again at edge A+LAT+1.
    logic [63:0] mem [int];
    int          e = 0;
    int          m_acc = 0;
    bit          m_active = 0;
    bit          m_we = 0;
    int          m_idx = 0;
    logic [63:0] m_wd = '0;
    logic        m_rdy = 0;
    logic [63:0] m_rdata = '0;
    logic        m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_rdy    = 0;
            m_rdata  = '0;
            m_err    = 0;
        end else begin
            e++;
            m_rdy = 0;
            if (m_active) begin
`ifdef UMEM_PROTO_CHK_EN
                if (e <= m_acc + LAT && (int'(u_addr[15:2]) != m_idx || !(u_re || u_we)))
                    m_err = 1;
`endif
                if (e == m_acc + LAT) begin
                    if (m_we) mem[m_idx] = m_wd;
                    else      m_rdata = mem.exists(m_idx) ? mem[m_idx] : 64'h0;
                    m_rdy = 1;
                end else if (e == m_acc + LAT + 1) begin
                    m_active = 0;
                end
            end else if (u_re || u_we) begin
                m_active = 1;
                m_acc    = e;
                m_we     = u_we;
                m_idx    = int'(u_addr[15:2]);
                m_wd     = u_wdata;
`ifdef UMEM_PROTO_CHK_EN
                if (u_re && u_we) m_err = 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy",  64'(u_busy), 64'(m_active));
            chk("rdy",   64'(u_rdy),  64'(m_rdy));
            chk("rdata", u_rdata,     m_rdata);
            chk("err",   64'(u_err),  64'(m_err));
        end
    end

    task automatic xact(input logic re, input logic we, input logic [15:0] a,
                        input logic [63:0] d, input int chg_at, input logic [15:0] chg_a,
                        output logic [63:0] rd, output int lat);
        bit got;
        got = 0;
        rd  = '0;
        lat = 0;
        @(negedge clk);
        u_re = re; u_we = we; u_addr = a; u_wdata = d;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == chg_at) u_addr = chg_a;
            if (u_rdy) begin
                got = 1;
                rd  = u_rdata;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout: no u_rdy for addr %h", a);
        end
        u_re = 0; u_we = 0;
    endtask

    logic [63:0] rd;
    int          lat;
    logic        exp_err;

    initial begin
`ifdef UMEM_PROTO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(negedge clk);
        started = 1'b1;
        chk("reset_busy",  64'(u_busy), 64'h0);
        chk("reset_rdy",   64'(u_rdy),  64'h0);
        chk("reset_rdata", u_rdata,     64'h0);
        chk("reset_err",   64'(u_err),  64'h0);
        rst_n = 1'b1;

        xact(0, 1, 16'h0040, 64'hDEAD_BEEF_0123_4567, 0, 16'h0, rd, lat);
        chk("wr_latency", 64'(lat), 64'd5);
        chk("wr_rdata_held", rd, 64'h0);

        xact(1, 0, 16'h0043, 64'h0, 0, 16'h0, rd, lat);
        chk("rd_latency", 64'(lat), 64'd5);
        chk("rd_data", rd, 64'hDEAD_BEEF_0123_4567);

        xact(1, 1, 16'h0100, 64'h1, 0, 16'h0, rd, lat);
        chk("both_rdata_held", rd, 64'hDEAD_BEEF_0123_4567);
        xact(1, 0, 16'h0100, 64'h0, 0, 16'h0, rd, lat);
        chk("both_write_won", rd, 64'h1);
        chk("both_err", 64'(u_err), 64'(exp_err));

        // Hold the read across the ready cycle: expect exactly two pulses, LAT+2 apart.
        begin
            int pulses, first, cyc;
            pulses = 0; first = 0; cyc = 0;
            @(negedge clk);
            u_re = 1; u_addr = 16'h0043;
            while (pulses < 2 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (u_rdy) begin
                    pulses++;
                    if (pulses == 1) first = cyc;
                    else chk("hold_gap", 64'(cyc - first), 64'd6);
                    chk("hold_data", u_rdata, 64'hDEAD_BEEF_0123_4567);
                end
            end
            u_re = 0;
            chk("hold_pulses", 64'(pulses), 64'd2);
            repeat (3) @(negedge clk);
            chk("hold_no_third", 64'(u_rdy), 64'h0);
        end

        xact(0, 1, 16'h0200, 64'h55AA, 0, 16'h0, rd, lat);
        @(negedge clk);
        u_we = 1; u_addr = 16'h0200; u_wdata = 64'hFF;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        u_we = 0;
        #1;
        chk("abort_busy",  64'(u_busy), 64'h0);
        chk("abort_rdy",   64'(u_rdy),  64'h0);
        chk("abort_rdata", u_rdata,     64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        xact(1, 0, 16'h0200, 64'h0, 0, 16'h0, rd, lat);
        chk("abort_old_data", rd, 64'h55AA);
        chk("abort_err_cleared", 64'(u_err), 64'h0);

        xact(1, 0, 16'h0040, 64'h0, 2, 16'h0080, rd, lat);
        chk("addr_chg_data", rd, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        chk("addr_chg_err", 64'(u_err), 64'(exp_err));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
